// File: rtl/vm80_intc_pkg.sv
// Shared definitions for the vm80 vectored interrupt controller.
package vm80_intc_pkg;

  localparam logic [1:0] ADR_IRR  = 2'd0;
  localparam logic [1:0] ADR_IMR  = 2'd1;
  localparam logic [1:0] ADR_ISR  = 2'd2;
  localparam logic [1:0] ADR_TRIG = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } intc_state_t;

  // RST n opcode: 11nnn111.
  function automatic logic [7:0] rst_op(input logic [2:0] n);
    return 8'hC7 | {2'b00, n, 3'b000};
  endfunction

endpackage

// File: rtl/vm80_intc_prio.sv
// Fully nested priority encoder: bit 0 wins. A request is only eligible
// if its priority is strictly above the highest-priority in-service line.
module vm80_intc_prio (
  input  logic [7:0] i_req,
  input  logic [7:0] i_isr,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  logic w_blk;

  // Scan from highest priority; the first in-service bit blocks itself and everything below.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    w_blk   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i_isr[i]) w_blk = 1'b1;
      if (!w_blk && !o_valid && i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/vm80_intc.sv
// 8-line vectored interrupt controller with a Wishbone register port.
// Raises cpu_int and supplies an RST n opcode during the CPU INTA cycle.
module vm80_intc
  import vm80_intc_pkg::*;
#(
  parameter logic [7:0] RST_IMR  = 8'hFF,
  parameter logic [7:0] RST_TRIG = 8'hFF,
  parameter logic [7:0] SPUR_VEC = 8'hFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  input  logic [7:0] irq_i,
  input  logic       cpu_sync,
  input  logic       cpu_stat0,
  output logic       cpu_int,
  output logic       vec_oe,
  output logic [7:0] vec_o
);

  logic [7:0]  r_irr, r_imr, r_isr, r_trig, r_irq_prev, r_dat, r_vec;
  logic        r_ack, r_int, r_oe;
  intc_state_t r_st, w_st_nxt;

  logic       w_ack, w_wr, w_inta, w_acc, w_take, w_valid;
  logic       w_int_nxt, w_oe_nxt;
  logic [7:0] w_vec_nxt;
  logic [2:0] w_idx;
  logic [7:0] w_irr, w_win_oh, w_clr, w_edge, w_isr_eoi;

  // Ack is registered, so a held strobe gets ack every other cycle.
  assign w_ack  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr   = w_ack & wb_we_i;
  assign w_inta = cpu_sync & cpu_stat0;

  // Edge bits come from the sticky register, level bits straight from the pins.
  assign w_irr    = (r_irr & r_trig) | (irq_i & ~r_trig);
  assign w_win_oh = 8'h01 << w_idx;
  assign w_take   = w_acc & w_valid;
  assign w_edge   = irq_i & ~r_irq_prev & r_trig;
  assign w_clr    = ((w_wr && wb_adr_i == ADR_IRR) ? wb_dat_i : 8'h00) |
                    (w_take ? w_win_oh : 8'h00);
  // EOI retires the highest-priority (lowest-index) in-service line.
  assign w_isr_eoi = (w_wr && wb_adr_i == ADR_ISR) ? (r_isr & (r_isr - 8'd1)) : r_isr;

  vm80_intc_prio u_prio (
    .i_req   (w_irr & ~r_imr),
    .i_isr   (r_isr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  // Next state and next CPU-side outputs; INTA is accepted from IDLE or REQ.
  always_comb begin
    w_st_nxt  = r_st;
    w_int_nxt = r_int;
    w_oe_nxt  = r_oe;
    w_vec_nxt = r_vec;
    w_acc     = 1'b0;
    case (r_st)
      ST_IDLE, ST_REQ: begin
        if (w_inta) begin
          w_acc     = 1'b1;
          w_st_nxt  = ST_ACK;
          w_int_nxt = 1'b0;
          w_oe_nxt  = 1'b1;
          w_vec_nxt = w_valid ? rst_op(w_idx) : SPUR_VEC;
        end else if (r_st == ST_IDLE && w_valid) begin
          w_st_nxt  = ST_REQ;
          w_int_nxt = 1'b1;
        end
      end
      ST_ACK: begin
        if (cpu_sync && !cpu_stat0) begin
          w_st_nxt = ST_IDLE;
          w_oe_nxt = 1'b0;
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_st <= ST_IDLE;
    else          r_st <= w_st_nxt;
  end

  // CPU-side output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_int <= 1'b0;
      r_oe  <= 1'b0;
      r_vec <= SPUR_VEC;
    end else begin
      r_int <= w_int_nxt;
      r_oe  <= w_oe_nxt;
      r_vec <= w_vec_nxt;
    end
  end

  // Request/service/mask registers; a new edge beats a same-cycle clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_irr      <= 8'h00;
      r_isr      <= 8'h00;
      r_imr      <= RST_IMR;
      r_trig     <= RST_TRIG;
      r_irq_prev <= 8'h00;
    end else begin
      r_irq_prev <= irq_i;
      r_irr      <= ((r_irr & ~w_clr) | w_edge) & r_trig;
      r_isr      <= w_isr_eoi | (w_take ? w_win_oh : 8'h00);
      if (w_wr && wb_adr_i == ADR_IMR)  r_imr  <= wb_dat_i;
      if (w_wr && wb_adr_i == ADR_TRIG) r_trig <= wb_dat_i;
    end
  end

  // Bus ack and registered read data, both loaded on the ack edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 8'h00;
    end else begin
      r_ack <= w_ack;
      if (w_ack) begin
        case (wb_adr_i)
          ADR_IRR: r_dat <= w_irr;
          ADR_IMR: r_dat <= r_imr;
          ADR_ISR: r_dat <= r_isr;
          default: r_dat <= r_trig;
        endcase
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign cpu_int  = r_int;
  assign vec_oe   = r_oe;
  assign vec_o    = r_vec;

endmodule
